// File: rtl/count_enable_gen.sv
// count_enable_gen
// -----------------------------------------------------------------------------
// Produces clean single-cycle step pulses for the downstream 4-bit up counter.
// A step comes either from a debounced pushbutton (manual mode) or from a
// free-running prescaler (auto mode).
//
// Datapath: 2-flop synchronizer -> debounce FSM -> press event
//           prescale counter                    -> tick
//           count_enable register selects press event or tick by mode.
//
// Ports:
//   clock        in   system clock, rising edge
//   clear_n      in   synchronous active-low reset
//   btn_raw      in   asynchronous pushbutton level, active-high, may bounce
//   mode         in   0 = manual step from button, 1 = free-run from prescaler
//   run          in   free-run gate, ignored when mode = 0
//   count_enable out  one-cycle step pulse to the counter
//   btn_level    out  debounced button level
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synchronized samples needed to accept a new level
//   PRESCALE         clock cycles per pulse in free-run mode (>= 2)
//   REPEAT_DELAY     hold cycles before auto-repeat starts (repeat build only)
//
// Build option:
//   COUNT_ENABLE_GEN_AUTO_REPEAT_EN - when defined, a held button in manual
//   mode auto-repeats every PRESCALE cycles once REPEAT_DELAY cycles have
//   elapsed in PRESSED. When undefined, exactly one pulse per press.
// -----------------------------------------------------------------------------
module count_enable_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PRESCALE        = 10
`ifdef COUNT_ENABLE_GEN_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 50
`endif
) (
  input  logic clock,
  input  logic clear_n,
  input  logic btn_raw,
  input  logic mode,
  input  logic run,
  output logic count_enable,
  output logic btn_level
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  localparam int PS_W = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronizer: only the second stage is ever looked at.
  // ---------------------------------------------------------------------------
  logic [1:0] sync_reg;
  logic       btn_sync;

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], btn_raw};
    end
  end

  assign btn_sync = sync_reg[1];

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------
  state_t          state_reg, state_next;
  logic [DB_W-1:0] cnt_reg, cnt_next;
  logic            press_evt;

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_reg <= RELEASED;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    press_evt  = 1'b0;
    case (state_reg)
      RELEASED: begin
        if (btn_sync) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_next = RELEASED;
        end else if (cnt_reg == DB_LAST) begin
          state_next = PRESSED;
          press_evt  = 1'b1;
        end else begin
          cnt_next = cnt_reg + DB_ONE;
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to 1 returns to PRESSED without a new press event.
        if (btn_sync) begin
          state_next = PRESSED;
        end else if (cnt_reg == DB_LAST) begin
          state_next = RELEASED;
        end else begin
          cnt_next = cnt_reg + DB_ONE;
        end
      end
      default: begin
        state_next = RELEASED;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Free-run prescaler; held at zero whenever it is not selected so the first
  // tick always lands PRESCALE cycles after run rises.
  // ---------------------------------------------------------------------------
  logic            free_run;
  logic            tick;
  logic [PS_W-1:0] pcnt_reg, pcnt_next;

  assign free_run = mode & run;
  assign tick     = free_run && (pcnt_reg == PS_LAST);

  always_comb begin
    pcnt_next = '0;
    if (free_run && (pcnt_reg != PS_LAST)) begin
      pcnt_next = pcnt_reg + PS_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      pcnt_reg <= '0;
    end else begin
      pcnt_reg <= pcnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Auto-repeat (optional)
  // ---------------------------------------------------------------------------
  logic rep_tick;

`ifdef COUNT_ENABLE_GEN_AUTO_REPEAT_EN
  localparam int RD_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(REPEAT_DELAY);
  localparam logic [RD_W-1:0] RD_ONE  = RD_W'(1);

  logic            held;
  logic [RD_W-1:0] dcnt_reg, dcnt_next;
  logic [PS_W-1:0] rpcnt_reg, rpcnt_next;

  // Counting only while staying in PRESSED: leaving it (including a dip into
  // RELEASE_WAIT) restarts the whole delay.
  assign held     = (state_reg == PRESSED) && (state_next == PRESSED);
  assign rep_tick = held && (dcnt_reg == RD_LAST) && (rpcnt_reg == PS_LAST);

  always_comb begin
    dcnt_next  = '0;
    rpcnt_next = '0;
    if (held) begin
      if (dcnt_reg != RD_LAST) begin
        dcnt_next = dcnt_reg + RD_ONE;
      end else begin
        dcnt_next = dcnt_reg;
        if (rpcnt_reg != PS_LAST) begin
          rpcnt_next = rpcnt_reg + PS_ONE;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      dcnt_reg  <= '0;
      rpcnt_reg <= '0;
    end else begin
      dcnt_reg  <= dcnt_next;
      rpcnt_reg <= rpcnt_next;
    end
  end
`else
  assign rep_tick = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output registers. The source not selected by mode is simply ignored, so
  // an event from it on a mode change is dropped rather than deferred.
  // ---------------------------------------------------------------------------
  logic count_enable_reg, count_enable_next;
  logic btn_level_reg, btn_level_next;

  assign count_enable_next = mode ? tick : (press_evt | rep_tick);
  assign btn_level_next    = (state_next == PRESSED) || (state_next == RELEASE_WAIT);

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      count_enable_reg <= 1'b0;
      btn_level_reg    <= 1'b0;
    end else begin
      count_enable_reg <= count_enable_next;
      btn_level_reg    <= btn_level_next;
    end
  end

  assign count_enable = count_enable_reg;
  assign btn_level    = btn_level_reg;

endmodule

// File: tb/tb_count_enable_gen.sv
// tb_count_enable_gen
// Edge numbering: edge n is the n-th rising clock edge. Expected pulses are
// queued as "count_enable high in the cycle after edge n"; expected button
// levels as "btn_level value right after edge n". The monitor samples 1 time
// unit after each rising edge and checks count_enable every cycle.
module tb_count_enable_gen;

  localparam int DB = 4;
  localparam int PS = 10;

  logic clock   = 1'b0;
  logic clear_n = 1'b0;
  logic btn_raw = 1'b1;
  logic mode    = 1'b1;
  logic run     = 1'b1;
  logic count_enable;
  logic btn_level;

  count_enable_gen #(
    .DEBOUNCE_CYCLES(DB),
    .PRESCALE(PS)
  ) dut (
    .clock(clock),
    .clear_n(clear_n),
    .btn_raw(btn_raw),
    .mode(mode),
    .run(run),
    .count_enable(count_enable),
    .btn_level(btn_level)
  );

  always #5 clock = ~clock;

  typedef struct {
    int   edge_n;
    logic val;
  } lvl_chk_t;

  // Button scenario record: pat is applied LSB first, one bit per edge starting
  // at base edge b, last bit held for hold edges, then the button is released.
  typedef struct {
    string       name;
    logic        mode;
    int          len;
    logic [15:0] pat;
    int          hold;
    int          pulse_off;  // pulse after edge b+pulse_off, -1 = none
    int          rise_off;   // btn_level rises at edge b+rise_off, -1 = never
  } btn_vec_t;

  int       pulse_q[$];
  lvl_chk_t lvl_q[$];
  int       cyc   = 0;
  int       n_vec = 0;
  int       n_err = 0;
  string    cur_name = "reset";

  task automatic expect_level(input int e, input logic v);
    lvl_chk_t c;
    c.edge_n = e;
    c.val    = v;
    lvl_q.push_back(c);
  endtask

  // Return at the falling edge before edge n so that inputs driven now are
  // sampled by edge n.
  task automatic goto_sample(input int n);
    while (cyc < n - 1) @(negedge clock);
  endtask

  // Scoreboard / monitor
  always @(posedge clock) begin
    logic exp_ce;
    cyc = cyc + 1;
    #1;
    exp_ce = (pulse_q.size() > 0) && (pulse_q[0] == cyc);
    if (exp_ce) void'(pulse_q.pop_front());
    n_vec++;
    if (count_enable !== exp_ce) begin
      n_err++;
      $display("FAIL %s count_enable after edge %0d: got %b required %b",
               cur_name, cyc, count_enable, exp_ce);
    end
    while (lvl_q.size() > 0 && lvl_q[0].edge_n <= cyc) begin
      n_vec++;
      if (btn_level !== lvl_q[0].val) begin
        n_err++;
        $display("FAIL %s btn_level after edge %0d: got %b required %b",
                 cur_name, lvl_q[0].edge_n, btn_level, lvl_q[0].val);
      end
      void'(lvl_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    btn_vec_t vecs[7];
    int b, rel, r, e;

    vecs[0] = '{"clean_press",    1'b0, 1, 16'h0001, 39,  6,  6};
    vecs[1] = '{"bounce_1010",    1'b0, 5, 16'h0015, 20, 10, 10};
    vecs[2] = '{"glitch_3",       1'b0, 3, 16'h0007,  0, -1, -1};
    vecs[3] = '{"glitch_4",       1'b0, 4, 16'h000F,  0, -1, -1};
    vecs[4] = '{"min_press_5",    1'b0, 5, 16'h001F,  0,  6,  6};
    vecs[5] = '{"release_bounce", 1'b0, 9, 16'h017F, 10,  6,  6};
    vecs[6] = '{"press_in_mode1", 1'b1, 1, 16'h0001, 20, -1,  6};

    // Reset held for edges 1..3 with button pressed and free-run on.
    // Release sampled at edge 4: tick after edge 13, button accepted at 10.
    expect_level(1, 1'b0);
    expect_level(2, 1'b0);
    expect_level(3, 1'b0);
    expect_level(9, 1'b0);
    expect_level(10, 1'b1);
    expect_level(20, 1'b1);
    expect_level(21, 1'b0);
    pulse_q.push_back(13);
    goto_sample(4);
    clear_n = 1'b1;
    goto_sample(15);
    mode    = 1'b0;
    run     = 1'b0;
    btn_raw = 1'b0;
    goto_sample(30);

    // Table-driven button scenarios
    for (int v = 0; v < 7; v++) begin
      cur_name = vecs[v].name;
      mode     = vecs[v].mode;
      run      = 1'b0;
      btn_raw  = 1'b0;
      b   = cyc + 3;
      rel = b + vecs[v].len + vecs[v].hold;
      if (vecs[v].pulse_off >= 0) pulse_q.push_back(b + vecs[v].pulse_off);
      if (vecs[v].rise_off >= 0) begin
        expect_level(b + vecs[v].rise_off - 1, 1'b0);
        expect_level(b + vecs[v].rise_off, 1'b1);
        expect_level(rel + 5, 1'b1);
        expect_level(rel + 6, 1'b0);
      end else begin
        expect_level(b + 6, 1'b0);
      end
      for (int i = 0; i < vecs[v].len; i++) begin
        goto_sample(b + i);
        btn_raw = vecs[v].pat[i];
      end
      goto_sample(rel);
      btn_raw = 1'b0;
      goto_sample(rel + 15);
    end

    // Free-run: run rises at edge r, drops at r+52, rises again at r+60.
    cur_name = "free_run";
    r = cyc + 2;
    for (int k = 0; k < 5; k++) pulse_q.push_back(r + 9 + 10 * k);
    pulse_q.push_back(r + 69);
    goto_sample(r);
    mode = 1'b1;
    run  = 1'b1;
    goto_sample(r + 52);
    run = 1'b0;
    goto_sample(r + 60);
    run = 1'b1;
    goto_sample(r + 72);
    run  = 1'b0;
    mode = 1'b0;
    goto_sample(r + 80);

    // Pending tick dropped by switching to mode 0 on the tick edge.
    cur_name = "mode_switch_tick";
    r = cyc + 2;
    goto_sample(r);
    mode = 1'b1;
    run  = 1'b1;
    goto_sample(r + 9);
    mode = 1'b0;
    goto_sample(r + 15);
    run = 1'b0;

    // Pending tick dropped by lowering run on the tick edge.
    cur_name = "run_drop_tick";
    r = cyc + 2;
    goto_sample(r);
    mode = 1'b1;
    run  = 1'b1;
    goto_sample(r + 9);
    run = 1'b0;
    goto_sample(r + 15);
    mode = 1'b0;

    // Press event dropped by switching to mode 1 on the press edge.
    cur_name = "mode_switch_press";
    b = cyc + 3;
    expect_level(b + 6, 1'b1);
    expect_level(b + 25, 1'b1);
    expect_level(b + 26, 1'b0);
    goto_sample(b);
    btn_raw = 1'b1;
    goto_sample(b + 6);
    mode = 1'b1;
    goto_sample(b + 20);
    btn_raw = 1'b0;
    goto_sample(b + 30);
    mode = 1'b0;

    // Reset during debounce restarts the whole path.
    cur_name = "reset_mid_debounce";
    b = cyc + 3;
    pulse_q.push_back(b + 11);
    expect_level(b + 4, 1'b0);
    expect_level(b + 10, 1'b0);
    expect_level(b + 11, 1'b1);
    expect_level(b + 35, 1'b1);
    expect_level(b + 36, 1'b0);
    goto_sample(b);
    btn_raw = 1'b1;
    goto_sample(b + 4);
    clear_n = 1'b0;
    goto_sample(b + 5);
    clear_n = 1'b1;
    goto_sample(b + 30);
    btn_raw = 1'b0;
    goto_sample(b + 45);

    // Long hold: single pulse, plus repeats in the auto-repeat build.
    cur_name = "long_hold";
    b   = cyc + 3;
    e   = b + 6;
    rel = e + 101;
    pulse_q.push_back(e);
`ifdef COUNT_ENABLE_GEN_AUTO_REPEAT_EN
    for (int k = 0; k < 5; k++) pulse_q.push_back(e + 60 + 10 * k);
`endif
    expect_level(e, 1'b1);
    expect_level(rel + 5, 1'b1);
    expect_level(rel + 6, 1'b0);
    goto_sample(b);
    btn_raw = 1'b1;
    goto_sample(rel);
    btn_raw = 1'b0;
    goto_sample(rel + 30);

    @(negedge clock);
    cur_name = "end";
    n_vec++;
    if (pulse_q.size() != 0 || lvl_q.size() != 0) begin
      n_err++;
      $display("FAIL end_queues: got %0d pulses and %0d levels outstanding required 0 and 0",
               pulse_q.size(), lvl_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
